vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
// Parametrised VGA raster timing generator; successor to the fixed-mode sync block.
// Sits between PIXEL_CLK and the pixel pipeline. Produces the pixel/line counters,
// blanking qualifiers, line and frame strobes, and syncs with exact widths.
// Adds a pixel clock-enable and a delay line (PIPE_DELAY) that keeps syncs and
// blanking aligned with a downstream pixel pipeline of known depth.
// PARAMETERS
// CNTR_WIDTH   13   counter width for locX/locY; H_TOTAL-1 and V_TOTAL-1 must fit
// H_ACTIVE     640  visible pixels per line
// H_FP         16   horizontal front porch, pixels
// H_SYNC       96   hsync width, pixels (>=1)
// H_BP         48   horizontal back porch, pixels
// V_ACTIVE     480  visible lines per frame
// V_FP         10   vertical front porch, lines
// V_SYNC       2    vsync width, lines (>=1)
// V_BP         33   vertical back porch, lines
// H_SYNC_POL   0    1 = hsync active-high, 0 = active-low
// V_SYNC_POL   0    1 = vsync active-high, 0 = active-low
// PIPE_DELAY   0    extra pixel stages (0..15) applied to the *_d outputs
// PORTS
// PIXEL_CLK    in   1           pixel clock
// RESET        in   1           synchronous, active-high reset
// PIX_CE       in   1           pixel enable; all state advances only when high
// locX         out  CNTR_WIDTH  current pixel column, 0..H_TOTAL-1
// locY         out  CNTR_WIDTH  current line, 0..V_TOTAL-1
// in_image_x   out  1           locX < H_ACTIVE
// in_image_y   out  1           locY < V_ACTIVE
// in_image     out  1           in_image_x & in_image_y
// line_start   out  1           high for pixel (0, any line)
// frame_start  out  1           high for pixel (0,0)
// sync_h       out  1           hsync, polarity per H_SYNC_POL
// sync_v       out  1           vsync, polarity per V_SYNC_POL
// in_image_d   out  1           in_image delayed PIPE_DELAY enabled pixels
// sync_h_d     out  1           sync_h delayed PIPE_DELAY enabled pixels
// sync_v_d     out  1           sync_v delayed PIPE_DELAY enabled pixels
// BEHAVIOUR
// - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
// - Internal counters x, y. On RESET: x=y=0, outputs go to reset values, delay line is flushed.
// - Reset values: loc*=0, in_image*=0, line/frame_start=0, syncs and *_d at the inactive level (~POL).
// - RESET takes priority over PIX_CE. Reset asserted mid-frame restarts from (0,0).
// - Each PIX_CE=1 cycle: outputs register the decode of (x,y), then (x,y) advances.
//   x wraps at H_TOTAL-1 to 0 and increments y; y wraps at V_TOTAL-1 to 0.
// - PIX_CE=0: counters, outputs and delay line all hold. Consumers qualify strobes with PIX_CE.
// - Latency is 1 enabled cycle from counter to outputs. The first enabled cycle after
//   reset presents (0,0) with frame_start=line_start=in_image=1.
// - hsync is active for x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]: exactly H_SYNC pixels.
// - vsync is active for y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], for all x on those lines.
// - *_d = output path through PIPE_DELAY CE-gated registers; PIPE_DELAY=0 gives *_d equal to
//   the undelayed output. During reset and flush, each delay stage loads the inactive value.
// - Elaboration error if H_TOTAL or V_TOTAL exceeds 2**CNTR_WIDTH, or H_SYNC/V_SYNC = 0.
// TESTING (small mode: H 8/2/2/2 -> H_TOTAL 14, V 4/1/1/1 -> V_TOTAL 7, POL=0, CE=1)
// - Reset, then release -> 1st cycle: loc=(0,0), frame_start=1, in_image=1.
//   Frame period is exactly 98 cycles between frame_start pulses.
// - One line -> in_image_x high for x=0..7; sync_h low only at x=10,11 (2 cycles).
//   line_start pulses every 14 cycles.
// - One frame -> sync_v low only on lines 5; in_image_y high on lines 0..3;
//   locY wraps 6->0 together with locX wrapping 13->0.
// - PIX_CE toggled 1,0,1,0 -> outputs advance once per high cycle and are frozen on low cycles.
//   Frame period becomes 196 clocks.
// - PIPE_DELAY=3 -> sync_h_d, sync_v_d and in_image_d equal sync_h, sync_v and in_image
//   from 3 enabled cycles earlier. Inactive (1,1,0) for the first 3 cycles after reset.
// - RESET asserted at loc=(9,2) for 1 cycle -> next cycle outputs are at reset values.
//   The following cycle shows (0,0) with frame_start=1. Default 640x480 params -> 800x525 period.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel/line counters, blanking qualifiers,
// line/frame strobes and syncs, plus a CE-gated delay line for pipeline-aligned copies.
module vga_timing_gen #(
    parameter int CNTR_WIDTH = 13,
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0,
    parameter int PIPE_DELAY = 0
) (
    input  logic                  PIXEL_CLK,
    input  logic                  RESET,
    input  logic                  PIX_CE,
    output logic [CNTR_WIDTH-1:0] locX,
    output logic [CNTR_WIDTH-1:0] locY,
    output logic                  in_image_x,
    output logic                  in_image_y,
    output logic                  in_image,
    output logic                  line_start,
    output logic                  frame_start,
    output logic                  sync_h,
    output logic                  sync_v,
    output logic                  in_image_d,
    output logic                  sync_h_d,
    output logic                  sync_v_d
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNTR_WIDTH-1:0] H_LAST   = CNTR_WIDTH'(H_TOTAL - 1);
    localparam logic [CNTR_WIDTH-1:0] V_LAST   = CNTR_WIDTH'(V_TOTAL - 1);
    localparam logic [CNTR_WIDTH-1:0] H_ACT_W  = CNTR_WIDTH'(H_ACTIVE);
    localparam logic [CNTR_WIDTH-1:0] V_ACT_W  = CNTR_WIDTH'(V_ACTIVE);
    localparam logic [CNTR_WIDTH-1:0] HS_FIRST = CNTR_WIDTH'(H_ACTIVE + H_FP);
    localparam logic [CNTR_WIDTH-1:0] HS_LAST  = CNTR_WIDTH'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNTR_WIDTH-1:0] VS_FIRST = CNTR_WIDTH'(V_ACTIVE + V_FP);
    localparam logic [CNTR_WIDTH-1:0] VS_LAST  = CNTR_WIDTH'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic                  HS_ON    = H_SYNC_POL;
    localparam logic                  VS_ON    = V_SYNC_POL;

    if ((H_TOTAL > 2**CNTR_WIDTH) || (V_TOTAL > 2**CNTR_WIDTH)) begin : g_err_width
        $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit in CNTR_WIDTH");
    end
    if ((H_SYNC < 1) || (V_SYNC < 1)) begin : g_err_sync
        $error("vga_timing_gen: H_SYNC and V_SYNC must be at least 1");
    end
    if ((PIPE_DELAY < 0) || (PIPE_DELAY > 15)) begin : g_err_delay
        $error("vga_timing_gen: PIPE_DELAY must be in 0..15");
    end

    logic [CNTR_WIDTH-1:0] x_q, x_d, y_q, y_d;
    logic [CNTR_WIDTH-1:0] locx_q, locx_d, locy_q, locy_d;
    logic                  inx_q, inx_d, iny_q, iny_d, img_q, img_d;
    logic                  lstart_q, lstart_d, fstart_q, fstart_d;
    logic                  hs_q, hs_d, vs_q, vs_d;

    always_comb begin
        // NOTE: every _d starts at its held value, so no path through this block infers a latch.
        x_d      = x_q;
        y_d      = y_q;
        locx_d   = locx_q;
        locy_d   = locy_q;
        inx_d    = inx_q;
        iny_d    = iny_q;
        img_d    = img_q;
        lstart_d = lstart_q;
        fstart_d = fstart_q;
        hs_d     = hs_q;
        vs_d     = vs_q;
        if (PIX_CE) begin
            locx_d   = x_q;
            locy_d   = y_q;
            inx_d    = (x_q < H_ACT_W);
            iny_d    = (y_q < V_ACT_W);
            img_d    = (x_q < H_ACT_W) && (y_q < V_ACT_W);
            lstart_d = (x_q == '0);
            fstart_d = (x_q == '0) && (y_q == '0);
            hs_d     = ((x_q >= HS_FIRST) && (x_q <= HS_LAST)) ? HS_ON : ~HS_ON;
            vs_d     = ((y_q >= VS_FIRST) && (y_q <= VS_LAST)) ? VS_ON : ~VS_ON;
            if (x_q == H_LAST) begin
                x_d = '0;
                y_d = (y_q == V_LAST) ? '0 : y_q + CNTR_WIDTH'(1);
            end else begin
                x_d = x_q + CNTR_WIDTH'(1);
            end
        end
    end

    // NOTE: sequential state is written with <= only, so every flop samples pre-edge values.
    always_ff @(posedge PIXEL_CLK) begin
        if (RESET) begin
            x_q      <= '0;
            y_q      <= '0;
            locx_q   <= '0;
            locy_q   <= '0;
            inx_q    <= 1'b0;
            iny_q    <= 1'b0;
            img_q    <= 1'b0;
            lstart_q <= 1'b0;
            fstart_q <= 1'b0;
            hs_q     <= ~HS_ON;
            vs_q     <= ~VS_ON;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            locx_q   <= locx_d;
            locy_q   <= locy_d;
            inx_q    <= inx_d;
            iny_q    <= iny_d;
            img_q    <= img_d;
            lstart_q <= lstart_d;
            fstart_q <= fstart_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
        end
    end

    assign locX        = locx_q;
    assign locY        = locy_q;
    assign in_image_x  = inx_q;
    assign in_image_y  = iny_q;
    assign in_image    = img_q;
    assign line_start  = lstart_q;
    assign frame_start = fstart_q;
    assign sync_h      = hs_q;
    assign sync_v      = vs_q;

    // Delay stages carry {in_image, sync_h, sync_v}; idle is blanked with both syncs inactive.
    localparam logic [2:0] IDLE_VEC = {1'b0, ~HS_ON, ~VS_ON};

    if (PIPE_DELAY == 0) begin : g_no_delay
        assign in_image_d = img_q;
        assign sync_h_d   = hs_q;
        assign sync_v_d   = vs_q;
    end else begin : g_delay
        logic [2:0] dly_q [PIPE_DELAY];
        logic [2:0] dly_d [PIPE_DELAY];

        always_comb begin
            for (int i = 0; i < PIPE_DELAY; i++) dly_d[i] = dly_q[i];
            if (PIX_CE) begin
                dly_d[0] = {img_q, hs_q, vs_q};
                for (int i = 1; i < PIPE_DELAY; i++) dly_d[i] = dly_q[i-1];
            end
        end

        // NOTE: the delay line is a short register chain, not RAM, so flushing it on reset is cheap and keeps stale syncs off the output.
        always_ff @(posedge PIXEL_CLK) begin
            if (RESET) begin
                for (int i = 0; i < PIPE_DELAY; i++) dly_q[i] <= IDLE_VEC;
            end else begin
                for (int i = 0; i < PIPE_DELAY; i++) dly_q[i] <= dly_d[i];
            end
        end

        assign {in_image_d, sync_h_d, sync_v_d} = dly_q[PIPE_DELAY-1];
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: hand vectors, period/corner sequences and
// randomized CE/reset traffic against an arithmetic raster model.
module tb_vga_timing_gen;

    typedef struct {
        int ha, hfp, hs, hbp;
        int va, vfp, vs, vbp;
    } mode_t;

    typedef struct {
        int x, y;
        bit inx, iny, img, ls, fs, hs, vs;
    } outs_t;

    typedef struct {
        bit rst, ce;
        int x, y;
        bit fs, ls, img, hs, vs;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic ce  = 1'b0;

    int total = 0;
    int bad   = 0;
    int n     = 0;   // enabled cycles since the last reset

    mode_t m_small = '{8, 2, 2, 2, 4, 1, 1, 1};
    mode_t m_big   = '{640, 16, 96, 48, 480, 10, 2, 33};

    // A: small mode, 3-stage delay; B: small mode, no delay; C: default 640x480
    logic [3:0]  a_lx, a_ly, b_lx, b_ly;
    logic [12:0] c_lx, c_ly;
    logic a_ix, a_iy, a_ii, a_ls, a_fs, a_sh, a_sv, a_iid, a_shd, a_svd;
    logic b_ix, b_iy, b_ii, b_ls, b_fs, b_sh, b_sv, b_iid, b_shd, b_svd;
    logic c_ix, c_iy, c_ii, c_ls, c_fs, c_sh, c_sv, c_iid, c_shd, c_svd;

    vga_timing_gen #(
        .CNTR_WIDTH(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .PIPE_DELAY(3)
    ) dut_a (
        .PIXEL_CLK(clk), .RESET(rst), .PIX_CE(ce),
        .locX(a_lx), .locY(a_ly), .in_image_x(a_ix), .in_image_y(a_iy),
        .in_image(a_ii), .line_start(a_ls), .frame_start(a_fs),
        .sync_h(a_sh), .sync_v(a_sv),
        .in_image_d(a_iid), .sync_h_d(a_shd), .sync_v_d(a_svd)
    );

    vga_timing_gen #(
        .CNTR_WIDTH(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .PIPE_DELAY(0)
    ) dut_b (
        .PIXEL_CLK(clk), .RESET(rst), .PIX_CE(ce),
        .locX(b_lx), .locY(b_ly), .in_image_x(b_ix), .in_image_y(b_iy),
        .in_image(b_ii), .line_start(b_ls), .frame_start(b_fs),
        .sync_h(b_sh), .sync_v(b_sv),
        .in_image_d(b_iid), .sync_h_d(b_shd), .sync_v_d(b_svd)
    );

    vga_timing_gen dut_c (
        .PIXEL_CLK(clk), .RESET(rst), .PIX_CE(ce),
        .locX(c_lx), .locY(c_ly), .in_image_x(c_ix), .in_image_y(c_iy),
        .in_image(c_ii), .line_start(c_ls), .frame_start(c_fs),
        .sync_h(c_sh), .sync_v(c_sv),
        .in_image_d(c_iid), .sync_h_d(c_shd), .sync_v_d(c_svd)
    );

    // Raster position of output count cnt, straight from the mode's porch arithmetic.
    function automatic outs_t decode(input mode_t m, input int cnt);
        outs_t o;
        int ht, vt, p;
        ht = m.ha + m.hfp + m.hs + m.hbp;
        vt = m.va + m.vfp + m.vs + m.vbp;
        o.x = 0; o.y = 0; o.inx = 0; o.iny = 0; o.img = 0;
        o.ls = 0; o.fs = 0; o.hs = 1; o.vs = 1;
        if (cnt > 0) begin
            p     = cnt - 1;
            o.x   = p % ht;
            o.y   = (p / ht) % vt;
            o.inx = (o.x < m.ha);
            o.iny = (o.y < m.va);
            o.img = o.inx && o.iny;
            o.ls  = (o.x == 0);
            o.fs  = (o.x == 0) && (o.y == 0);
            o.hs  = !((o.x >= m.ha + m.hfp) && (o.x < m.ha + m.hfp + m.hs));
            o.vs  = !((o.y >= m.va + m.vfp) && (o.y < m.va + m.vfp + m.vs));
        end
        return o;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_inst(input string tag, input mode_t m, input int dly,
                              input logic [12:0] lx, input logic [12:0] ly,
                              input logic ix, input logic iy, input logic ii,
                              input logic ls, input logic fs, input logic sh, input logic sv,
                              input logic iid, input logic shd, input logic svd);
        outs_t e, ed;
        e  = decode(m, n);
        ed = decode(m, (n > dly) ? n - dly : 0);
        check({tag, ".locX"}, 32'(lx), e.x);
        check({tag, ".locY"}, 32'(ly), e.y);
        check1({tag, ".in_image_x"}, ix, e.inx);
        check1({tag, ".in_image_y"}, iy, e.iny);
        check1({tag, ".in_image"}, ii, e.img);
        check1({tag, ".line_start"}, ls, e.ls);
        check1({tag, ".frame_start"}, fs, e.fs);
        check1({tag, ".sync_h"}, sh, e.hs);
        check1({tag, ".sync_v"}, sv, e.vs);
        check1({tag, ".in_image_d"}, iid, ed.img);
        check1({tag, ".sync_h_d"}, shd, ed.hs);
        check1({tag, ".sync_v_d"}, svd, ed.vs);
    endtask

    // One clock: drive on the falling edge, advance the model at the rising edge, sample 1 ns later.
    task automatic step(input bit r, input bit c);
        @(negedge clk);
        rst = r;
        ce  = c;
        @(posedge clk);
        if (r) n = 0;
        else if (c) n++;
        #1;
        check_inst("A", m_small, 3, 13'(a_lx), 13'(a_ly), a_ix, a_iy, a_ii, a_ls, a_fs,
                   a_sh, a_sv, a_iid, a_shd, a_svd);
        check_inst("B", m_small, 0, 13'(b_lx), 13'(b_ly), b_ix, b_iy, b_ii, b_ls, b_fs,
                   b_sh, b_sv, b_iid, b_shd, b_svd);
        check_inst("C", m_big, 0, c_lx, c_ly, c_ix, c_iy, c_ii, c_ls, c_fs,
                   c_sh, c_sv, c_iid, c_shd, c_svd);
    endtask

    vec_t vecs [9];

    initial begin
        int first, second, hlow, lcount, vlow, found, maxx;
        logic prev;

        vecs[0] = '{1, 1, 0, 0, 0, 0, 0, 1, 1};
        vecs[1] = '{0, 1, 0, 0, 1, 1, 1, 1, 1};
        vecs[2] = '{0, 1, 1, 0, 0, 0, 1, 1, 1};
        vecs[3] = '{0, 0, 1, 0, 0, 0, 1, 1, 1};
        vecs[4] = '{0, 1, 2, 0, 0, 0, 1, 1, 1};
        vecs[5] = '{0, 0, 2, 0, 0, 0, 1, 1, 1};
        vecs[6] = '{1, 0, 0, 0, 0, 0, 0, 1, 1};
        vecs[7] = '{1, 1, 0, 0, 0, 0, 0, 1, 1};
        vecs[8] = '{0, 1, 0, 0, 1, 1, 1, 1, 1};

        for (int i = 0; i < 9; i++) begin
            step(vecs[i].rst, vecs[i].ce);
            check($sformatf("vec%0d.locX", i), 32'(a_lx), vecs[i].x);
            check($sformatf("vec%0d.locY", i), 32'(a_ly), vecs[i].y);
            check1($sformatf("vec%0d.frame_start", i), a_fs, vecs[i].fs);
            check1($sformatf("vec%0d.line_start", i), a_ls, vecs[i].ls);
            check1($sformatf("vec%0d.in_image", i), a_ii, vecs[i].img);
            check1($sformatf("vec%0d.sync_h", i), a_sh, vecs[i].hs);
            check1($sformatf("vec%0d.sync_v", i), a_sv, vecs[i].vs);
            check1($sformatf("vec%0d.sync_h_d", i), a_shd, 1'b1);
            check1($sformatf("vec%0d.in_image_d", i), a_iid, 1'b0);
        end

        // Continuous CE: frame period, hsync width, strobes per frame.
        step(1, 1);
        first = -1; second = -1; hlow = 0; lcount = 0; vlow = 0;
        for (int k = 0; k < 250; k++) begin
            step(0, 1);
            if (a_fs === 1'b1) begin
                if (first < 0) first = k;
                else if (second < 0) second = k;
            end
            if (k < 14 && a_sh === 1'b0) hlow++;
            if (k < 98 && a_ls === 1'b1) lcount++;
            if (k < 98 && a_sv === 1'b0) vlow++;
        end
        check("frame_period_ce1", second - first, 98);
        check("hsync_low_per_line", hlow, 2);
        check("line_starts_per_frame", lcount, 7);
        check("vsync_low_per_frame", vlow, 14);

        // CE toggling 1,0,1,0: period doubles.
        step(1, 1);
        first = -1; second = -1; prev = 1'b0;
        for (int k = 0; k < 450; k++) begin
            step(0, (k % 2) == 0);
            if (a_fs === 1'b1 && prev !== 1'b1) begin
                if (first < 0) first = k;
                else if (second < 0) second = k;
            end
            prev = a_fs;
        end
        check("frame_period_ce_toggle", second - first, 196);

        // Reset asserted mid-frame at (9,2).
        step(1, 1);
        found = 0;
        for (int k = 0; k < 200 && found == 0; k++) begin
            step(0, 1);
            if (a_lx === 4'd9 && a_ly === 4'd2) found = 1;
        end
        check("reached_9_2", found, 1);
        step(1, 1);
        check("midreset.locX", 32'(a_lx), 0);
        check("midreset.locY", 32'(a_ly), 0);
        check1("midreset.frame_start", a_fs, 1'b0);
        check1("midreset.in_image", a_ii, 1'b0);
        check1("midreset.sync_h", a_sh, 1'b1);
        check1("midreset.sync_h_d", a_shd, 1'b1);
        check1("midreset.in_image_d", a_iid, 1'b0);
        step(0, 1);
        check1("after_reset.frame_start", a_fs, 1'b1);
        check1("after_reset.in_image", a_ii, 1'b1);
        check("after_reset.locX", 32'(a_lx), 0);

        // Default 640x480 mode: 800-pixel lines, 96-pixel hsync.
        step(1, 1);
        first = -1; second = -1; hlow = 0; maxx = 0;
        for (int k = 0; k < 1700; k++) begin
            step(0, 1);
            if (c_ls === 1'b1) begin
                if (first < 0) first = k;
                else if (second < 0) second = k;
            end
            if (k < 800 && c_sh === 1'b0) hlow++;
            if (32'(c_lx) > maxx) maxx = 32'(c_lx);
        end
        check("default_line_period", second - first, 800);
        check("default_hsync_width", hlow, 96);
        check("default_max_locX", maxx, 799);

        // Random CE with occasional reset.
        for (int k = 0; k < 3000; k++) begin
            step($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
